quant_seq: RTL and testbench

- Quantization sequencer for one 8x8 DCT block of 64 coefficients.
- Walks the inverse-quantization ROM (romq) by coefficient index and pairs each incoming DCT coefficient with its ROM byte, allowing for the ROM's one-cycle registered read.
- Multiplies the coefficient by the ROM value, rounds, and emits the quantized coefficient on a valid/ready stream.
- Sits between the DCT output stage and the entropy/output stage; romq is instantiated alongside it and connected through rom_addr/rom_data.

---
 rtl/quant_seq_pkg.sv | 21 ++
 rtl/quant_seq_if.sv | 25 ++
 rtl/quant_seq_mul.sv | 27 ++
 rtl/quant_seq.sv | 98 +++++++++
 tb/tb_quant_seq.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quant_seq_pkg.sv
// Shared constants and state encoding for the quantization sequencer.
// Imported by the interface, the multiplier and the sequencer top.
package quant_pkg;

  localparam int CW    = 16;
  localparam int QW    = 8;
  localparam int FRAC  = 8;
  localparam int NCOEF = 64;
  localparam int IW    = 6;

  localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    ACCEPT,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/quant_seq_if.sv
// Coefficient-in and quantized-out valid/ready streams.
// The slave modport is the sequencer side.
interface quant_seq_if;
  import quant_pkg::*;

  logic                 coef_valid;
  logic signed [CW-1:0] coef_data;
  logic                 coef_ready;

  logic                 q_valid;
  logic signed [CW-1:0] q_data;
  logic                 q_last;
  logic                 q_ready;

  modport master (
    output coef_valid, coef_data, q_ready,
    input  coef_ready, q_valid, q_data, q_last
  );

  modport slave (
    input  coef_valid, coef_data, q_ready,
    output coef_ready, q_valid, q_data, q_last
  );

endinterface

// File: rtl/quant_seq_mul.sv
// Signed coefficient times unsigned Q0.8 ROM value,
// rounded half-up and shifted back to coefficient width.
module quant_mul
  import quant_pkg::*;
(
  input  logic signed [CW-1:0] i_coef,
  input  logic        [QW-1:0] i_rom,
  output logic signed [CW-1:0] o_q
);

  localparam int PW = CW + QW + 1;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (FRAC - 1));

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_s;

  assign w_a = PW'(i_coef);
  assign w_b = $signed(PW'(i_rom));
  assign w_p = w_a * w_b;
  assign w_s = w_p + RND;

  // |p| >> FRAC always fits CW, so plain truncation is safe
  assign o_q = CW'(w_s >>> FRAC);

endmodule

// File: rtl/quant_seq.sv
// Quantization sequencer: walks romq by index, pairs each
// coefficient with its ROM byte and streams the rounded product.
module quant_seq
  import quant_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  output logic [IW-1:0] o_rom_addr,
  input  logic [QW-1:0] i_rom_data,
  output logic          o_busy,
  output logic          o_done,
  quant_seq_if.slave    bus
);

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic                 r_coef_ready;
  logic                 r_q_valid;
  logic signed [CW-1:0] r_q_data;
  logic                 r_q_last;
  logic                 r_busy;
  logic                 r_done;
  logic signed [CW-1:0] w_q;

  quant_mul u_mul (
    .i_coef (bus.coef_data),
    .i_rom  (i_rom_data),
    .o_q    (w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_coef_ready <= 1'b0;
      r_q_valid    <= 1'b0;
      r_q_data     <= '0;
      r_q_last     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= PRIME;
          end
        end
        // romq read latency: rom_data for idx is valid next cycle
        PRIME: begin
          r_coef_ready <= 1'b1;
          r_state      <= ACCEPT;
        end
        ACCEPT: begin
          if (bus.coef_valid) begin
            r_coef_ready <= 1'b0;
            r_q_data     <= w_q;
            r_q_valid    <= 1'b1;
            r_q_last     <= (r_idx == LAST_IDX);
            r_idx        <= r_idx + 1'b1;
            r_state      <= OUT;
          end
        end
        OUT: begin
          if (bus.q_ready) begin
            r_q_valid <= 1'b0;
            if (r_q_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_coef_ready <= 1'b1;
              r_state      <= ACCEPT;
            end
          end
        end
        DONE: begin
          r_q_last <= 1'b0;
          r_idx    <= '0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rom_addr     = r_idx;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign bus.coef_ready = r_coef_ready;
  assign bus.q_valid    = r_q_valid;
  assign bus.q_data     = r_q_data;
  assign bus.q_last     = r_q_last;

endmodule

// File: tb/tb_quant_seq.sv
// Scoreboard bench for quant_seq with a registered romq model
// and an arithmetic reference for the rounded quantization.
module tb_quant_seq;
  import quant_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] rom_addr;
  logic [QW-1:0] rom_data;
  logic          busy;
  logic          done;

  quant_seq_if bus();

  quant_seq dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_busy     (busy),
    .o_done     (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [CW-1:0] d;
    logic                 l;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] rom [64];
  int total = 0;
  int bad = 0;
  int acc_idx = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int rdy_mode = 0;
  logic                 hold_v = 1'b0;
  logic signed [CW-1:0] hold_d = '0;
  logic                 hold_l = 1'b0;
  logic                 exp_done = 1'b0;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // round(c*r/256) half toward +inf, by floor division
  function automatic logic signed [CW-1:0] ref_q(input int c, input int r);
    int p;
    int f;
    p = c * r + 128;
    if (p >= 0) f = p / 256;
    else f = -((-p + 255) / 256);
    return f[CW-1:0];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    bus.q_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.q_ready = 1'b0;
        1: bus.q_ready = 1'b1;
        default: bus.q_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      acc_idx = 0;
      hold_v = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (exp_done || done) chk("done_pulse", done, exp_done);
      exp_done = 1'b0;
      if (hold_v) begin
        chk("hold_valid", bus.q_valid, 1);
        chk("hold_data", bus.q_data, hold_d);
        chk("hold_last", bus.q_last, hold_l);
      end
      if (bus.coef_valid && bus.coef_ready) begin
        chk("accept_qvalid_low", bus.q_valid, 0);
        e.d = ref_q(int'(bus.coef_data), int'(rom[acc_idx]));
        e.l = (acc_idx == 63);
        sbq.push_back(e);
        acc_idx = (acc_idx + 1) % 64;
      end
      if (bus.q_valid) begin
        chk("coef_ready_in_out", bus.coef_ready, 0);
        if (bus.q_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL q_unexpected: got %0d with nothing expected",
                     bus.q_data);
          end else begin
            e = sbq.pop_front();
            chk("q_data", bus.q_data, e.d);
            chk("q_last", bus.q_last, e.l);
            exp_done = e.l;
          end
        end
      end
      hold_v = bus.q_valid && !bus.q_ready;
      hold_d = bus.q_data;
      hold_l = bus.q_last;
    end
  end

  task automatic send(input int c);
    bit ok;
    ok = 1'b0;
    bus.coef_valid = 1'b1;
    bus.coef_data = CW'(c);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.coef_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no coef_ready expected within 200");
    end
    @(posedge clk);
    #1;
    bus.coef_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy got 1 expected 0 within 3000");
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic int rnd_coef();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(1, 255));
    rom[0]  = 8'hFF;
    rom[7]  = 8'h3C;
    rom[63] = 8'h19;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q_valid", bus.q_valid, 0);
    chk("rst_q_data", bus.q_data, 0);
    chk("rst_q_last", bus.q_last, 0);
    chk("rst_coef_ready", bus.coef_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // block A: first output under backpressure, then random ready
    rdy_mode = 0;
    pulse_start();
    @(negedge clk);
    chk("prime_busy", busy, 1);
    chk("prime_rom_addr", rom_addr, 0);
    send(256);
    @(negedge clk);
    chk("lat_q_valid", bus.q_valid, 1);
    chk("lat_coef_ready", bus.coef_ready, 0);
    chk("lat_q_data", bus.q_data, 255);
    chk("bp_rom_addr", rom_addr, 1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_coef_ready", bus.coef_ready, 0);
      chk("bp_rom_addr", rom_addr, 1);
    end
    rdy_mode = 1;
    for (int i = 1; i < 64; i++) begin
      if (i == 2) rdy_mode = 2;
      send(i == 7 ? -100 : rnd_coef());
    end
    wait_idle();
    chk("blockA_done_cnt", done_cnt, 1);

    // block B: full-rate block of 1000s, start while busy
    rdy_mode = 1;
    @(posedge clk);
    #1;
    busy_cyc = 0;
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      if (i == 30) start = 1'b1;
      send(1000);
      start = 1'b0;
    end
    wait_idle();
    chk("blockB_cycles", busy_cyc, 130);
    chk("blockB_done_cnt", done_cnt, 2);

    // block C: reset at idx 20, then a fresh block
    rdy_mode = 2;
    @(posedge clk);
    #1;
    pulse_start();
    for (int i = 0; i < 20; i++) send(rnd_coef());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_q_valid", bus.q_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("restart_rom_addr", rom_addr, 0);
    send(-1);
    for (int i = 1; i < 64; i++) send(rnd_coef());
    wait_idle();
    repeat (3) @(negedge clk);
    chk("blockC_done_cnt", done_cnt, 3);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
